// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch port: request/address out, ready/data back in the same cycle.
// Master is the fetch sequencer; slave is the memory side.
interface fetch_sequencer_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch PC sequencer feeding the IF/ID output register; 1-cycle request->if_valid latency, 1 instr/cycle at zero wait.
// Backpressure: freeze holds a full output register and suppresses new requests; a raised request is held until mem_ready.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     freeze,
    input  logic                     branch_taken,
    input  logic [31:0]              branch_addr,
    fetch_sequencer_if.master        mem,
    output logic                     if_valid,
    output logic [31:0]              if_pc,
    output logic [31:0]              if_instr,
    output logic                     fetch_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

    localparam logic [7:0] C_TMO = 8'(TIMEOUT_CYC);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_drop_pc;
    logic        r_pend;
    logic [7:0]  r_wait_cnt;
    logic        r_if_valid;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_instr;
    logic        r_fetch_err;

    logic        w_free;
    logic        w_req;
    logic        w_rsp;
    logic [31:0] w_target;

    // A held (frozen) word blocks new requests, but a request already on the bus stays up.
    assign w_free   = !r_if_valid || !freeze;
    assign w_req    = ((r_state == S_REQ) && (w_free || r_pend)) || (r_state == S_DROP);
    assign w_rsp    = w_req && mem.mem_ready;
    assign w_target = branch_addr & 32'hFFFF_FFFC;

    assign mem.mem_req  = w_req;
    assign mem.mem_addr = (r_state == S_DROP) ? r_drop_pc : r_pc;

    assign if_valid  = r_if_valid;
    assign if_pc     = r_if_pc;
    assign if_instr  = r_if_instr;
    assign fetch_err = r_fetch_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_drop_pc   <= '0;
            r_pend      <= 1'b0;
            r_wait_cnt  <= '0;
            r_if_valid  <= 1'b0;
            r_if_pc     <= '0;
            r_if_instr  <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            if (w_rsp) begin
                r_wait_cnt <= '0;
            end else if (w_req) begin
                if (r_wait_cnt != C_TMO) begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                end
                if (r_wait_cnt >= C_TMO - 8'd1) begin
                    r_fetch_err <= 1'b1;
                end
            end

            r_pend <= (r_state == S_REQ) && w_req && !mem.mem_ready && !branch_taken;

            if (branch_taken) begin
                r_pc <= w_target;
            end else if ((r_state == S_REQ) && w_rsp) begin
                r_pc <= r_pc + 32'd4;
            end

            // A redirect with a request still in flight must wait out the old response at the old address.
            case (r_state)
                S_IDLE: r_state <= S_REQ;
                S_REQ: begin
                    if (branch_taken && w_req && !mem.mem_ready) begin
                        r_state   <= S_DROP;
                        r_drop_pc <= r_pc;
                    end
                end
                S_DROP: begin
                    if (mem.mem_ready) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (branch_taken) begin
                r_if_valid <= 1'b0;
            end else if ((r_state == S_REQ) && w_rsp) begin
                r_if_valid <= 1'b1;
                r_if_pc    <= r_pc;
                r_if_instr <= mem.mem_rdata;
            end else if (!freeze) begin
                r_if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a default-parameter instance driven by a variable-latency memory model with a scoreboard,
// plus a second instance (RESET_PC=FFFF_FFF8, TIMEOUT_CYC=4) for wrap-around and timeout.
module tb_fetch_sequencer;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        fetch_err;

    logic        rst2 = 1'b0;
    logic        freeze2 = 1'b0;
    logic        branch2 = 1'b0;
    logic [31:0] branch_addr2 = '0;
    logic        m2_en = 1'b0;
    logic        if_valid2;
    logic [31:0] if_pc2;
    logic [31:0] if_instr2;
    logic        fetch_err2;

    int vectors = 0;
    int miscompares = 0;

    fetch_sequencer_if mf ();
    fetch_sequencer_if mf2 ();

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    fetch_sequencer u_dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .mem          (mf),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .fetch_err    (fetch_err)
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFF8), .TIMEOUT_CYC(4)) u_dut2 (
        .clk          (clk),
        .rst          (rst2),
        .freeze       (freeze2),
        .branch_taken (branch2),
        .branch_addr  (branch_addr2),
        .mem          (mf2),
        .if_valid     (if_valid2),
        .if_pc        (if_pc2),
        .if_instr     (if_instr2),
        .fetch_err    (fetch_err2)
    );

    assign mf2.mem_ready = mf2.mem_req && m2_en;
    assign mf2.mem_rdata = instr_of(mf2.mem_addr);

    always #5 clk = ~clk;

    // Memory model: answers after `lat` wait cycles of a continuous request.
    int   lat = 0;
    int   m_wcnt = 0;
    logic m_prev_req = 1'b0;
    logic m_prev_rdy = 1'b0;

    initial begin
        mf.mem_ready = 1'b0;
        mf.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (m_prev_req && !m_prev_rdy) m_wcnt++;
            else m_wcnt = 0;
            mf.mem_ready = mf.mem_req && (m_wcnt >= lat);
            mf.mem_rdata = instr_of(mf.mem_addr);
            m_prev_req   = mf.mem_req;
            m_prev_rdy   = mf.mem_ready;
        end
    end

    // Scoreboard: accepted responses push the expected IF word; new IF words pop and compare.
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] exp_addr = '0;
    logic        squash = 1'b0;
    logic [31:0] sq_target = '0;
    logic        mon_en = 1'b0;
    logic        p_valid = 1'b0;
    logic        p_freeze = 1'b0;
    logic        p_branch = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (if_valid && !(p_valid && p_freeze && !p_branch)) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_unexpected_word got pc=%h instr=%h, required no word", if_pc, if_instr);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (if_pc !== mon_e.pc || if_instr !== mon_e.instr) begin
                        miscompares++;
                        $display("FAIL sb_if_word got pc=%h instr=%h, required pc=%h instr=%h",
                                 if_pc, if_instr, mon_e.pc, mon_e.instr);
                    end
                end
            end
            p_valid  = if_valid;
            p_freeze = freeze;
            p_branch = branch_taken;
            if (mf.mem_req) begin
                vectors++;
                if (mf.mem_addr !== exp_addr) begin
                    miscompares++;
                    $display("FAIL sb_mem_addr got %h, required %h", mf.mem_addr, exp_addr);
                end
                if (mf.mem_ready) begin
                    if (squash) begin
                        exp_addr = sq_target;
                        squash   = 1'b0;
                    end else if (branch_taken) begin
                        exp_addr = branch_addr & 32'hFFFF_FFFC;
                    end else begin
                        exp_q.push_back('{pc: exp_addr, instr: instr_of(exp_addr)});
                        exp_addr = exp_addr + 32'd4;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiesce();
        tick();
        freeze = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!mf.mem_req) break;
        end
        repeat (2) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0; lat = 0;
        exp_addr = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (if_valid !== 1'b0)   begin miscompares++; $display("FAIL reset_if_valid got %b, required 0", if_valid); end
        vectors++; if (if_pc !== 32'h0)     begin miscompares++; $display("FAIL reset_if_pc got %h, required 0", if_pc); end
        vectors++; if (if_instr !== 32'h0)  begin miscompares++; $display("FAIL reset_if_instr got %h, required 0", if_instr); end
        vectors++; if (fetch_err !== 1'b0)  begin miscompares++; $display("FAIL reset_fetch_err got %b, required 0", fetch_err); end
        vectors++; if (mf.mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req got %b, required 0", mf.mem_req); end
        tick();
        rst    = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_stream();
        @(negedge clk);
        vectors++; if (mf.mem_req !== 1'b0) begin miscompares++; $display("FAIL idle_mem_req got %b, required 0", mf.mem_req); end
        @(negedge clk);
        vectors++; if (mf.mem_req !== 1'b1 || if_valid !== 1'b0) begin
            miscompares++; $display("FAIL first_req got req=%b valid=%b, required req=1 valid=0", mf.mem_req, if_valid);
        end
        @(negedge clk);
        vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || mf.mem_addr !== 32'h4) begin
            miscompares++; $display("FAIL first_word got valid=%b pc=%h addr=%h, required valid=1 pc=0 addr=4", if_valid, if_pc, mf.mem_addr);
        end
        repeat (8) tick();
        quiesce();
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL stream_drain got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_wait_freeze();
        logic [31:0] hold_pc;
        int n;
        hold_pc = exp_addr;
        lat = 3;
        n = 0;
        tick();
        freeze = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (if_valid) break;
        end
        freeze = 1'b1;
        vectors++; if (n != 4) begin miscompares++; $display("FAIL wait_latency got %0d cycles, required 4", n); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (if_valid !== 1'b1 || if_pc !== hold_pc || if_instr !== instr_of(hold_pc) || mf.mem_req !== 1'b0) begin
                miscompares++;
                $display("FAIL freeze_hold got valid=%b pc=%h instr=%h req=%b, required valid=1 pc=%h instr=%h req=0",
                         if_valid, if_pc, if_instr, mf.mem_req, hold_pc, instr_of(hold_pc));
            end
        end
        tick();
        freeze = 1'b0;
        repeat (12) tick();
        quiesce();
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL wait_drain got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_branch_drop();
        int n;
        lat = 3;
        tick();
        branch_taken = 1'b1; branch_addr = 32'h0000_0040; exp_addr = 32'h0000_0040;
        tick();
        branch_taken = 1'b0;
        vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("FAIL branch_frozen_clear got %b, required 0", if_valid); end
        freeze = 1'b0;
        tick();
        vectors++; if (mf.mem_req !== 1'b1) begin miscompares++; $display("FAIL drop_outstanding got req=%b, required 1", mf.mem_req); end
        branch_taken = 1'b1; branch_addr = 32'h0000_0102; squash = 1'b1; sq_target = 32'h0000_0100;
        tick();
        branch_taken = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if_valid) break;
            n++;
        end
        vectors++; if (if_pc !== 32'h0000_0100 || n < 5) begin
            miscompares++; $display("FAIL drop_first_word got pc=%h after %0d empty cycles, required pc=100 after >=5", if_pc, n);
        end
        repeat (6) tick();
        quiesce();
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL drop_drain got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_branch_same_ready();
        lat = 1;
        tick();
        freeze = 1'b0;
        tick();
        freeze = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #2;
            if (mf.mem_ready) break;
            tick();
        end
        branch_taken = 1'b1; branch_addr = 32'h0000_0200;
        tick();
        branch_taken = 1'b0;
        vectors++; if (if_valid !== 1'b0 || mf.mem_req !== 1'b1 || mf.mem_addr !== 32'h0000_0200) begin
            miscompares++; $display("FAIL same_ready_redirect got valid=%b req=%b addr=%h, required valid=0 req=1 addr=200",
                                    if_valid, mf.mem_req, mf.mem_addr);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (if_valid) break;
        end
        vectors++; if (if_pc !== 32'h0000_0200) begin miscompares++; $display("FAIL same_ready_word got pc=%h, required 200", if_pc); end
        quiesce();
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL same_ready_drain got %0d pending, required 0", exp_q.size()); end
        vectors++; if (fetch_err !== 1'b0) begin miscompares++; $display("FAIL main_fetch_err got %b, required 0", fetch_err); end
    endtask

    task automatic test_wrap();
        logic [31:0] q2[$];
        logic [31:0] e;
        logic [31:0] prev;
        logic        have_prev;
        rst2 = 1'b0; m2_en = 1'b1;
        repeat (2) tick();
        rst2 = 1'b1;
        q2.push_back(32'hFFFF_FFF8); q2.push_back(32'hFFFF_FFFC);
        q2.push_back(32'h0000_0000); q2.push_back(32'h0000_0004);
        have_prev = 1'b0;
        prev = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (have_prev) begin
                vectors++;
                if (if_valid2 !== 1'b1 || if_pc2 !== prev || if_instr2 !== instr_of(prev)) begin
                    miscompares++; $display("FAIL wrap_trail got valid=%b pc=%h, required valid=1 pc=%h", if_valid2, if_pc2, prev);
                end
            end
            have_prev = 1'b0;
            if (mf2.mem_req && mf2.mem_ready && q2.size() > 0) begin
                e = q2.pop_front();
                vectors++;
                if (mf2.mem_addr !== e) begin miscompares++; $display("FAIL wrap_addr got %h, required %h", mf2.mem_addr, e); end
                prev = e;
                have_prev = 1'b1;
            end
        end
        vectors++; if (q2.size() != 0) begin miscompares++; $display("FAIL wrap_count got %0d unseen, required 0", q2.size()); end
    endtask

    task automatic test_timeout();
        tick();
        rst2 = 1'b0; m2_en = 1'b0;
        tick();
        vectors++; if (fetch_err2 !== 1'b0) begin miscompares++; $display("FAIL tmo_reset got %b, required 0", fetch_err2); end
        rst2 = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            vectors++;
            if (mf2.mem_req !== 1'b1 || fetch_err2 !== (k >= 5)) begin
                miscompares++; $display("FAIL tmo_wait%0d got req=%b err=%b, required req=1 err=%b", k, mf2.mem_req, fetch_err2, (k >= 5));
            end
        end
        m2_en = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (fetch_err2 !== 1'b1) begin miscompares++; $display("FAIL tmo_sticky got %b, required 1", fetch_err2); end
        tick();
        rst2 = 1'b0;
        #1;
        vectors++; if (fetch_err2 !== 1'b0) begin miscompares++; $display("FAIL tmo_clear got %b, required 0", fetch_err2); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_wait_freeze();
        test_branch_drop();
        test_branch_same_ready();
        test_wrap();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
